// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter through a tx_data / tx_transmit / tx_ready handshake.
// Optional sticky overflow flag with ovf / ovf_clr ports when UART_TX_FIFO_OVF_EN is defined.
module uart_tx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [7:0]            wr_data,
    input  logic                  wr_en,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level,
    output logic [7:0]            tx_data,
    output logic                  tx_transmit,
    input  logic                  tx_ready
`ifdef UART_TX_FIFO_OVF_EN
    ,
    output logic                  ovf,
    input  logic                  ovf_clr
`endif
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   LEVEL_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   LEVEL_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND     = 2'd1,
        WAIT_ACK = 2'd2
    } state_t;

    state_t                  state_reg, state_next;
    logic [7:0]              mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [DEPTH_LOG2:0]     level_reg;
    logic [7:0]              tx_data_reg;
    logic                    tx_transmit_reg, tx_transmit_next;
    logic                    push, pop;

    assign full        = (level_reg == LEVEL_FULL);
    assign empty       = (level_reg == '0);
    assign level       = level_reg;
    assign tx_data     = tx_data_reg;
    assign tx_transmit = tx_transmit_reg;

    // full is taken from the registered level, so a pop cannot make room for a same-cycle write
    assign push = wr_en && !full;

    always_comb begin
        state_next       = state_reg;
        pop              = 1'b0;
        tx_transmit_next = 1'b0;
        case (state_reg)
            IDLE: begin
                // an X on tx_ready falls to the else path: no pop
                if (tx_ready == 1'b1 && !empty) begin
                    pop              = 1'b1;
                    tx_transmit_next = 1'b1;
                    state_next       = SEND;
                end
            end
            SEND:     state_next = WAIT_ACK;
            WAIT_ACK: if (tx_ready == 1'b0) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_reg] <= wr_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= IDLE;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            level_reg       <= '0;
            tx_data_reg     <= 8'h00;
            tx_transmit_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            tx_transmit_reg <= tx_transmit_next;
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            if (pop) begin
                tx_data_reg <= mem[rd_ptr_reg];
                rd_ptr_reg  <= rd_ptr_reg + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   level_reg <= level_reg + LEVEL_ONE;
                2'b01:   level_reg <= level_reg - LEVEL_ONE;
                default: level_reg <= level_reg;
            endcase
        end
    end

`ifdef UART_TX_FIFO_OVF_EN
    logic ovf_reg;

    // a dropped write in the same cycle as a clear leaves the flag set
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_reg <= 1'b0;
        end else if (wr_en && full) begin
            ovf_reg <= 1'b1;
        end else if (ovf_clr) begin
            ovf_reg <= 1'b0;
        end
    end

    assign ovf = ovf_reg;
`endif

endmodule
